// File: rtl/logic_unit_serial.sv
// rtl/logic_unit_serial.sv - serial eight-function logic unit, LANE result bits per clock
// Optional accumulator operand selected by defining LOGIC_UNIT_ACC_EN.
module logic_unit_serial #(
  parameter int WIDTH = 8,
  parameter int LANE  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       key,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             parity,
  output logic             busy
);

  localparam int STEPS = WIDTH / LANE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_res;
  logic [2:0]       r_key;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_zero;
  logic             r_parity;
  logic             r_busy;

  logic [WIDTH-1:0] w_func;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_y_sel;

  always_comb begin
    w_func = '0;
    case (r_key)
      3'b000: w_func = r_x | r_y;
      3'b001: w_func = ~(r_x | r_y);
      3'b010: w_func = r_x ^ r_y;
      3'b011: w_func = ~(r_x ^ r_y);
      3'b100: w_func = r_x & r_y;
      3'b101: w_func = ~(r_x & r_y);
      3'b110: w_func = ~r_x;
      default: w_func = r_x;
    endcase
  end

  // Result with the current lane merged in; on the last step this is the complete word.
  always_comb begin
    w_next = r_res;
    w_next[int'(r_cnt)*LANE +: LANE] = w_func[int'(r_cnt)*LANE +: LANE];
  end

`ifdef LOGIC_UNIT_ACC_EN
  logic [WIDTH-1:0] r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (r_out_valid && out_ready) begin
      r_acc <= r_res;
    end
  end

  assign w_y_sel = use_acc ? r_acc : y;
`else
  logic w_unused_use_acc;
  assign w_unused_use_acc = use_acc;
  assign w_y_sel = y;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_key       <= '0;
      r_res       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_zero      <= 1'b0;
      r_parity    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_x        <= x;
            r_y        <= w_y_sel;
            r_key      <= key;
            r_res      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_res <= w_next;
          if (r_cnt == LAST) begin
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_zero      <= (w_next == '0);
            r_parity    <= ^w_next;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign r         = r_res;
  assign zero      = r_zero;
  assign parity    = r_parity;
  assign busy      = r_busy;

endmodule

// File: tb/tb_logic_unit_serial.sv
// tb/tb_logic_unit_serial.sv - self-checking bench for logic_unit_serial
module tb_logic_unit_serial;

  localparam int WIDTH = 8;
  localparam int LANE  = 2;
  localparam int STEPS = WIDTH / LANE;
`ifdef LOGIC_UNIT_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             use_acc = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] x = '0;
  logic [WIDTH-1:0] y = '0;
  logic [2:0]       key = '0;
  logic             in_ready;
  logic             out_valid;
  logic             zero;
  logic             parity;
  logic             busy;
  logic [WIDTH-1:0] r;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  logic_unit_serial #(.WIDTH(WIDTH), .LANE(LANE)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .key(key), .use_acc(use_acc),
    .out_valid(out_valid), .out_ready(out_ready), .r(r),
    .zero(zero), .parity(parity), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [WIDTH-1:0] logic_fn(input logic [2:0] k, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (k)
      3'd0: return a | b;
      3'd1: return ~(a | b);
      3'd2: return a ^ b;
      3'd3: return ~(a ^ b);
      3'd4: return a & b;
      3'd5: return ~(a & b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  // Model: an op accepted at edge t is busy until edge t+STEPS, then valid until handshake.
  int               cyc = 0;
  int               m_t = 0;
  bit               m_active = 1'b0;
  bit               m_live = 1'b0;
  logic [WIDTH-1:0] m_r = '0;
  logic [WIDTH-1:0] m_acc = '0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_active = 1'b0;
      m_r = '0;
      m_acc = '0;
      m_live = 1'b1;
    end else if (m_live) begin
      if (!m_active) begin
        if (in_valid) begin
          m_active = 1'b1;
          m_t = cyc;
          m_r = logic_fn(key, x, (ACC && use_acc) ? m_acc : y);
        end
      end else if ((cyc - 1 >= m_t + STEPS) && out_ready) begin
        m_active = 1'b0;
        m_acc = m_r;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live && !reset) begin
      check("in_ready", in_ready, !m_active);
      check("busy", busy, m_active && (cyc < m_t + STEPS));
      check("out_valid", out_valid, m_active && (cyc >= m_t + STEPS));
      if (m_active && (cyc >= m_t + STEPS)) begin
        check("r", r, m_r);
        check("zero", zero, m_r == '0);
        check("parity", parity, ^m_r);
      end
    end
  end

  task automatic issue(input logic [2:0] k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic ua);
    int n;
    @(negedge clk);
    key = k; x = a; y = b; use_acc = ua; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_chk++;
      $display("FAIL accept_wait: in_ready never rose, expected accept");
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; key = ~k; x = ~a; y = ~b; use_acc = ~ua;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 50) begin
      n_chk++;
      $display("FAIL done_wait: out_valid never rose, expected completion");
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] k, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic ua, input logic [WIDTH-1:0] exp);
    int lat;
    issue(k, a, b, ua);
    wait_done(lat);
    check(name, r, exp);
    handshake();
  endtask

  logic [WIDTH-1:0] exp_keys [8] = '{8'hEE, 8'h11, 8'h66, 8'h99, 8'h88, 8'h77, 8'h33, 8'hCC};

  initial begin
    int lat;
    int pulses;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_r", r, 8'h00);
    check("rst_zero", zero, 0);
    check("rst_parity", parity, 0);

    issue(3'b000, 8'hA5, 8'h0F, 1'b0);
    check("t2_busy", busy, 1);
    wait_done(lat);
    check("t2_latency", lat, 4);
    check("t2_r", r, 8'hAF);
    check("t2_zero", zero, 0);
    check("t2_parity", parity, 0);
    handshake();

    for (int k = 0; k < 8; k++) run_op("t3_key", 3'(k), 8'hCC, 8'hAA, 1'b0, exp_keys[k]);
    issue(3'b011, 8'hFF, 8'h00, 1'b0);
    wait_done(lat);
    check("t3_xnor_r", r, 8'h00);
    check("t3_xnor_zero", zero, 1);
    check("t3_xnor_parity", parity, 0);
    handshake();

    issue(3'b000, 8'h12, 8'h34, 1'b0);
    wait_done(lat);
    key = 3'b010; x = 8'h55; y = 8'h0F; use_acc = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_r", r, 8'h36);
      check("t4_hold_in_ready", in_ready, 0);
      check("t4_hold_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t4_release_out_valid", out_valid, 0);
    check("t4_release_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_accept_busy", busy, 1);
    wait_done(lat);
    check("t4_second_r", r, 8'h5A);
    handshake();

    issue(3'b000, 8'h81, 8'h42, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_r", r, 8'h00);
    check("t5_out_valid", out_valid, 0);
    check("t5_in_ready", in_ready, 1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("t5_no_pulse", pulses, 0);
    run_op("t5_after", 3'b010, 8'h0F, 8'hFF, 1'b0, 8'hF0);

    run_op("t6_op1", 3'b111, 8'h3C, 8'h00, 1'b0, 8'h3C);
    run_op("t6_op2", 3'b100, 8'hF0, 8'h00, 1'b1, ACC ? 8'h30 : 8'h00);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/logic_unit_serial.md
Name: logic_unit_serial

Overview:
Parametrised successor of the 1-bit four-function logic selector. Applies one of eight bitwise logic functions to two WIDTH-bit operands, LANE bits per clock. Input uses a valid/ready handshake, output uses a valid/ready handshake, and status flags are produced with the result. Sits between an operand source and a result consumer in the datapath exercises; 1-bit combinational behaviour is the WIDTH=LANE=1 special case, plus registering.

Parameters:
WIDTH, 8, operand/result width in bits
LANE, 2, bits processed per cycle; must divide WIDTH (LANE=WIDTH gives single-cycle processing)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands/key presented
in_ready  output  1  block can accept operands
x  input  WIDTH  operand x
y  input  WIDTH  operand y
key  input  3  function select
use_acc  input  1  replace y with accumulator (effective only with ACC_EN)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
r  output  WIDTH  result
zero  output  1  r == 0
parity  output  1  XOR-reduce of r
busy  output  1  high in BUSY

Behaviour:
- Reset (checked at the clk edge) sets the state to IDLE. All of the following are registered: in_ready=1, out_valid=0, r=0, zero=0, parity=0, busy=0, lane counter=0, accumulator=0. Reset wins over every other event.
- Key map:
  - 000 or, 001 nor, 010 xor, 011 xnor. These are the same codes as the 2-bit predecessor when key[2]=0.
  - 100 and, 101 nand, 110 not x, 111 pass x.
- The FSM has three states: IDLE, BUSY, DONE. STEPS = WIDTH/LANE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at an edge: latch x, y (or acc), key; set r=0, cnt=0; go to BUSY (in_ready=0, busy=1).
- BUSY:
  - Each cycle writes r[cnt*LANE +: LANE] = f(x,y) slice, then cnt++.
  - Bits not yet written keep their value of 0.
  - On the cycle with cnt==STEPS-1: after the write, go to DONE with out_valid=1, busy=0, cnt=0.
  - zero and parity are updated at that same edge from the complete result.
- DONE:
  - out_valid=1; r, zero and parity are held stable.
  - On out_valid & out_ready at an edge: out_valid=0, go to IDLE (in_ready=1 from the next cycle).
  - r/zero/parity hold their value until the next accept.
- Latency: accept at edge T means out_valid rises at edge T+STEPS (4 for the defaults). Minimum op-to-op interval is STEPS+2 cycles; there is no overlap.
- in_valid outside IDLE is ignored. Upstream must hold its data until in_ready.
- out_ready outside DONE is ignored. If out_ready is already high when out_valid rises, the transfer occurs at the following edge.
- Latched operands and key are immune to input changes after the accept.
- Reset during BUSY or DONE abandons the operation: IDLE, r=0, and no out_valid pulse.
- r is meaningful only while out_valid=1.

Optional Feature:
LOGIC_UNIT_ACC_EN
- Defined:
  - A WIDTH-bit accumulator exists, reset to 0.
  - If use_acc=1 at the accept edge, the accumulator is latched as operand y instead of the y port.
  - At every completion handshake (out_valid & out_ready) the accumulator loads r.
- Undefined: no accumulator register; use_acc is ignored; y is always used.

Test Plan:
1. reset=1 for 2 cycles, then 0 -> in_ready=1, out_valid=0, busy=0, r=0x00, zero=0, parity=0.
2. key=000, x=0xA5, y=0x0F, accepted at edge T -> busy for cycles T..T+3; out_valid=1 at T+4; r=0xAF, zero=0, parity=0.
3. x=0xCC, y=0xAA, each key in turn -> r = 0xEE, 0x11, 0x66, 0x99, 0x88, 0x77, 0x33, 0xCC. For key=011 with x=0xFF, y=0x00 -> r=0x00, zero=1, parity=0.
4. Backpressure: out_ready=0 for 5 cycles in DONE, with new in_valid asserted -> r/out_valid stable, in_ready=0, nothing accepted. Raise out_ready -> out_valid=0 next edge, in_ready=1, the pending input is accepted one cycle later.
5. reset=1 during the second BUSY cycle -> next cycle IDLE, r=0x00, out_valid never pulses. A following op (key=010, x=0x0F, y=0xFF) returns r=0xF0.
6. With LOGIC_UNIT_ACC_EN: op1 key=111, x=0x3C, completed -> acc=0x3C. Op2 key=100, x=0xF0, y=0x00, use_acc=1 -> r=0x30. Without the macro the same op2 gives r=0x00.
